// File: rtl/i2c_pkg.sv
// i2c_pkg: types and defaults used by the I2C register controller and its
// register file.
//   state_t       controller FSM states (IDLE, PTR, WRITE, READ)
//   byte_t        8-bit data byte
//   I2C_NUM_REGS  default register-file depth
//   I2C_OOR_DATA  default read data returned for an out-of-range pointer
package i2c_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PTR   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  localparam int    I2C_NUM_REGS = 16;
  localparam byte_t I2C_OOR_DATA = 8'hFF;

endpackage

// File: rtl/i2c_regfile.sv
// i2c_regfile: NUM_REGS x 8 register file, synchronous write, combinational read.
// Ports:
//   clk, reset  clock, asynchronous active-high reset (clears contents)
//   we          write enable
//   addr        read/write address
//   wdata       write data
//   rdata       combinational read data at addr
module i2c_regfile
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = I2C_NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  byte_t         wdata,
  output byte_t         rdata
);

  byte_t r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: bridges an I2C slave peripheral's byte strobes to an external
// register file. First written byte after START sets the pointer; further
// written bytes go to consecutive registers. Reads stream registers starting
// at the current pointer. The pointer survives a repeated START.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, rw         START/repeated START with address match; rw=1 read
//   byte_valid, rx    received byte strobe and data
//   tx_req            peripheral consumed tx, wants next byte
//   stop              STOP detected
//   tx                registered byte to transmit
//   reg_we/addr/wdata register-file write port
//   reg_rdata         combinational register-file read data at reg_addr
//   busy              FSM not idle
//   err               sticky out-of-range pointer flag, cleared on start
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int    NUM_REGS = I2C_NUM_REGS,
  parameter byte_t OOR_DATA = I2C_OOR_DATA,
  localparam int   AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rw,
  input  logic          byte_valid,
  input  byte_t         rx,
  input  logic          tx_req,
  input  logic          stop,
  output byte_t         tx,
  output logic          reg_we,
  output logic [AW-1:0] reg_addr,
  output byte_t         reg_wdata,
  input  byte_t         reg_rdata,
  output logic          busy,
  output logic          err
);

  localparam byte_t LAST_IDX = byte_t'(NUM_REGS - 1);

  state_t r_state, w_next;
  byte_t  r_ptr;
  byte_t  r_tx;
  logic   r_err;

  logic   w_ptr_ok;
  logic   w_rx_oor;
  logic   w_wr_acc;
  logic   w_rd_adv;
  byte_t  w_ptr_inc;

  // Pointer is a full byte so out-of-range values are remembered; the
  // 32-bit compare keeps NUM_REGS=256 correct.
  assign w_ptr_ok  = ({24'd0, r_ptr} < NUM_REGS);
  assign w_rx_oor  = ({24'd0, rx} >= NUM_REGS);
  assign w_ptr_inc = (r_ptr == LAST_IDX) ? 8'd0 : r_ptr + 8'd1;

  // start overrides any coincident byte_valid/tx_req in the same cycle.
  assign w_wr_acc = (r_state == WRITE) && byte_valid && !start && w_ptr_ok;
  assign w_rd_adv = (r_state == READ) && tx_req && !start && !stop && w_ptr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = rw ? READ : PTR;
    end else if (stop) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        PTR:     if (byte_valid) w_next = WRITE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_tx  <= '0;
      r_err <= 1'b0;
    end else begin
      if (start) begin
        r_err <= 1'b0;
      end else if (r_state == PTR && byte_valid) begin
        r_ptr <= rx;
        r_err <= w_rx_oor;
      end else if (w_wr_acc || w_rd_adv) begin
        r_ptr <= w_ptr_inc;
      end
      // tx tracks the pointer every READ cycle, so a pointer step shows up
      // one edge after it happens.
      if (r_state == READ)
        r_tx <= w_ptr_ok ? reg_rdata : OOR_DATA;
    end
  end

  assign tx        = r_tx;
  assign reg_we    = w_wr_acc;
  assign reg_addr  = r_ptr[AW-1:0];
  assign reg_wdata = rx;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

endmodule
